led_sw_ctrl: RTL and testbench
==============================

# led_sw_ctrl

Parametrised Avalon-MM peripheral for the HPS lightweight bridge. It replaces the fixed 8-LED core and the 4-bit switch PIO with one block: N_LED LED outputs, each either static or PWM-dimmed, and N_SW debounced switch inputs with edge capture and a maskable interrupt. It sits inside the Qsys system on the fabric clock. `led_out` and `sw_in` are exported as conduits to the top level.

## Interface
- N_LED, 8, LED channel count (1..16)
- N_SW, 4, switch channel count (1..16)
- PWM_BITS, 8, PWM duty/counter width (2..12)
- PRESCALE, 50, clk cycles per PWM counter step (>=1)
- DEBOUNCE_CYCLES, 50000, cycles a synced input must stay stable before acceptance (>=2)

Ports:
- clk  in  1  system clock; one clock for the whole block
- reset  in  1  synchronous, active-high reset
- avs_address  in  5  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, fixed read latency 1, no waitrequest
- irq  out  1  level interrupt, registered
- sw_in  in  N_SW  asynchronous switch inputs
- led_out  out  N_LED  registered LED drive

## Operation
- Register map (word addresses):
  - 0 CTRL: bit0 EN (global LED enable), bit1 IRQ_EN.
  - 1 SW_STATE: read-only, debounced switch values.
  - 2 SW_EDGE: captured changes, write-1-to-clear.
  - 3 SW_MASK: IRQ mask per switch.
  - 4 LED_MODE: per LED, 0 = static, 1 = PWM.
  - 5 LED_STATIC: static value.
  - 16+i DUTY[i]: PWM duty for i < N_LED, low PWM_BITS bits.
- Unmapped addresses read 0; writes to them are ignored. Bits above a field's width read 0.
- A read and a write in the same cycle both execute. readdata returns the pre-write value.
- Switch path, per channel:
  - 2-flop synchroniser.
  - Counter runs while synced != stable; it clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1: stable <= synced, counter clears, SW_EDGE[i] <= 1.
- SW_EDGE: a hardware set and a software clear in the same cycle resolve to set.
- irq <= IRQ_EN & |(SW_EDGE & SW_MASK).
- PWM:
  - The prescaler counts 0..PRESCALE-1 and ticks at PRESCALE-1.
  - pwm_cnt increments on each tick and wraps from 2^PWM_BITS-1 to 0.
  - DUTY writes go to a shadow register. Active duty loads from the shadow only when pwm_cnt wraps to 0, so no glitches occur mid-period.
  - PWM level = active_duty > pwm_cnt. Duty 0 = always off; duty 2^PWM_BITS-1 = on except one step per period.
- led_out[i] <= EN & (LED_MODE[i] ? pwm_level[i] : LED_STATIC[i]).

## Timing
- Reset values:
  - Outputs: led_out = 0, irq = 0, avs_readdata = 0.
  - State: all registers, counters, shadow/active duties, and stable values = 0.
- A switch that is high through reset yields a rising edge DEBOUNCE_CYCLES+2 cycles after reset deasserts.
- sw_in change held from cycle 0:
  - Synced value differs at cycle 2.
  - stable and SW_EDGE update at cycle DEBOUNCE_CYCLES+2.
  - irq asserts one cycle after that.
- A glitch shorter than DEBOUNCE_CYCLES leaves stable and SW_EDGE unchanged.
- CTRL/LED_MODE/LED_STATIC writes reach led_out one cycle after the write cycle.
- DUTY writes take effect at the next pwm_cnt wrap. PWM period = PRESCALE * 2^PWM_BITS cycles.
- Reset mid-operation clears everything in the cycle reset is sampled high. A pending edge is lost.

## Structure
- Package led_sw_pkg holds:
  - Register address constants (ADDR_CTRL..ADDR_DUTY_BASE).
  - CTRL bit indices.
  - Read-latency constant.
- Sub-module sw_debounce: one channel containing the synchroniser, counter, stable bit, and change pulse. It is generated N_SW times.
- PWM counter, register file, and bus logic live in led_sw_ctrl.

## Test plan
- Reset, then read all registers: every register reads 0 and led_out = 0. Unmapped address 7 reads 0.
- Run with DEBOUNCE_CYCLES=8:
  - A 5-cycle high pulse on sw_in[2] causes no SW_STATE/SW_EDGE change.
  - Holding it high sets SW_STATE[2] and SW_EDGE = 0x4 at cycle 10.
- Interrupt flow:
  - With SW_MASK=0x4 and CTRL=0x3, irq rises one cycle after the edge.
  - Writing SW_EDGE=0x4 drops irq the next cycle.
  - An edge arriving in the same cycle as the clear keeps SW_EDGE set.
- Static mode: with CTRL=1, LED_MODE=0, LED_STATIC=0xA5, led_out = 0xA5 one cycle after the write. CTRL=0 forces 0.
- PWM duty, with PWM_BITS=4, PRESCALE=2, LED_MODE=0x01:
  - DUTY[0]=4 gives 8 high cycles per 32-cycle period.
  - DUTY[0]=0 gives always low.
  - DUTY[0]=15 gives 30/32 high.
- Duty update mid-period: write DUTY[0]=12 at pwm_cnt=7. The current period keeps the old duty; the new duty appears starting at the next pwm_cnt=0.

Source files
------------

// File: rtl/led_sw_pkg.sv
// Shared constants for the LED/switch Avalon-MM peripheral: register map,
// CTRL bit positions and bus timing.
package led_sw_pkg;

  localparam logic [4:0] ADDR_CTRL       = 5'd0;
  localparam logic [4:0] ADDR_SW_STATE   = 5'd1;
  localparam logic [4:0] ADDR_SW_EDGE    = 5'd2;
  localparam logic [4:0] ADDR_SW_MASK    = 5'd3;
  localparam logic [4:0] ADDR_LED_MODE   = 5'd4;
  localparam logic [4:0] ADDR_LED_STATIC = 5'd5;
  localparam logic [4:0] ADDR_DUTY_BASE  = 5'd16;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int READ_LATENCY = 1;

endpackage

// File: rtl/sw_debounce.sv
// One switch channel: two-flop synchroniser, stability counter and the
// accepted (stable) level, with a one-cycle pulse when that level changes.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_async,
  output logic stable,
  output logic change
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;

  // Combinational so that stable and the captured edge update on the same clock.
  assign change = (sync_q2 != stable) && (cnt == CNT_LAST);

  // NOTE: clocked state always uses non-blocking assignments so every flop
  // samples the pre-edge values, which is what makes the synchroniser a chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      stable  <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_q1 <= sw_async;
      sync_q2 <= sync_q1;
      if (sync_q2 == stable) begin
        cnt <= '0;
      end else if (change) begin
        stable <= sync_q2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_sw_ctrl.sv
// Avalon-MM LED/switch peripheral: register file, PWM dimming per LED,
// debounced switches with edge capture and a maskable level interrupt.
module led_sw_ctrl
  import led_sw_pkg::*;
#(
  parameter int N_LED           = 8,
  parameter int N_SW            = 4,
  parameter int PWM_BITS        = 8,
  parameter int PRESCALE        = 50,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              irq,
  input  logic [N_SW-1:0]   sw_in,
  output logic [N_LED-1:0]  led_out
);

  localparam int                  PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX  = '1;

  logic [1:0]          ctrl;
  logic [N_SW-1:0]     sw_mask;
  logic [N_SW-1:0]     sw_edge;
  logic [N_SW-1:0]     sw_stable;
  logic [N_SW-1:0]     sw_change;
  logic [N_SW-1:0]     sw_edge_clr;
  logic [N_LED-1:0]    led_mode;
  logic [N_LED-1:0]    led_static;
  logic [N_LED-1:0]    pwm_level;
  logic [PWM_BITS-1:0] duty_shadow [N_LED];
  logic [PWM_BITS-1:0] duty_active [N_LED];
  logic [PRE_W-1:0]    prescale_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_tick;
  logic                pwm_wrap;
  logic [31:0]         rd_data;
  logic                unused_wdata;

  assign unused_wdata = ^avs_writedata;

  for (genvar g = 0; g < N_SW; g++) begin : g_sw
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .sw_async (sw_in[g]),
      .stable   (sw_stable[g]),
      .change   (sw_change[g])
    );
  end

  assign pwm_tick    = (prescale_cnt == PRE_LAST);
  assign pwm_wrap    = pwm_tick && (pwm_cnt == PWM_MAX);
  assign sw_edge_clr = (avs_write && avs_address == ADDR_SW_EDGE) ?
                       avs_writedata[N_SW-1:0] : '0;

  always_comb begin
    for (int i = 0; i < N_LED; i++) begin
      pwm_level[i] = duty_active[i] > pwm_cnt;
    end
  end

  // NOTE: every variable written here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rd_data = '0;
    case (avs_address)
      ADDR_CTRL:       rd_data = 32'(ctrl);
      ADDR_SW_STATE:   rd_data = 32'(sw_stable);
      ADDR_SW_EDGE:    rd_data = 32'(sw_edge);
      ADDR_SW_MASK:    rd_data = 32'(sw_mask);
      ADDR_LED_MODE:   rd_data = 32'(led_mode);
      ADDR_LED_STATIC: rd_data = 32'(led_static);
      default: begin
        for (int i = 0; i < N_LED; i++) begin
          if (avs_address == ADDR_DUTY_BASE + 5'(i)) rd_data = 32'(duty_shadow[i]);
        end
      end
    endcase
  end

  // NOTE: the duty arrays are reset element by element; they are small flop
  // arrays, not RAM, and a known-zero duty keeps the LEDs dark after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl         <= '0;
      sw_mask      <= '0;
      sw_edge      <= '0;
      led_mode     <= '0;
      led_static   <= '0;
      prescale_cnt <= '0;
      pwm_cnt      <= '0;
      avs_readdata <= '0;
      irq          <= 1'b0;
      led_out      <= '0;
      for (int i = 0; i < N_LED; i++) begin
        duty_shadow[i] <= '0;
        duty_active[i] <= '0;
      end
    end else begin
      avs_readdata <= avs_read ? rd_data : '0;

      if (avs_write) begin
        case (avs_address)
          ADDR_CTRL:       ctrl       <= avs_writedata[1:0];
          ADDR_SW_MASK:    sw_mask    <= avs_writedata[N_SW-1:0];
          ADDR_LED_MODE:   led_mode   <= avs_writedata[N_LED-1:0];
          ADDR_LED_STATIC: led_static <= avs_writedata[N_LED-1:0];
          default: ;
        endcase
        for (int i = 0; i < N_LED; i++) begin
          if (avs_address == ADDR_DUTY_BASE + 5'(i)) duty_shadow[i] <= avs_writedata[PWM_BITS-1:0];
        end
      end

      // Hardware set wins over a simultaneous software clear.
      sw_edge <= (sw_edge & ~sw_edge_clr) | sw_change;
      irq     <= ctrl[CTRL_IRQ_EN] & |(sw_edge & sw_mask);

      prescale_cnt <= pwm_tick ? '0 : prescale_cnt + 1'b1;
      if (pwm_tick) pwm_cnt <= pwm_cnt + 1'b1;
      // Active duty only changes at the period boundary to avoid mid-period glitches.
      if (pwm_wrap) begin
        for (int i = 0; i < N_LED; i++) duty_active[i] <= duty_shadow[i];
      end

      led_out <= ctrl[CTRL_EN] ? ((led_mode & pwm_level) | (~led_mode & led_static)) : '0;
    end
  end

endmodule

// File: tb/tb_led_sw_ctrl.sv
// Randomised and directed bench for led_sw_ctrl with a cycle-level reference
// model; bus reads are scoreboarded, led_out and irq are compared every cycle.
module tb_led_sw_ctrl;

  localparam int N_LED    = 8;
  localparam int N_SW     = 4;
  localparam int PWM_BITS = 4;
  localparam int PRESCALE = 2;
  localparam int DEB      = 8;
  localparam int STEPS    = 1 << PWM_BITS;
  localparam int PERIOD   = PRESCALE * STEPS;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [4:0]        avs_address = '0;
  logic              avs_read = 1'b0;
  logic              avs_write = 1'b0;
  logic [31:0]       avs_writedata = '0;
  logic [31:0]       avs_readdata;
  logic              irq;
  logic [N_SW-1:0]   sw_in = '0;
  logic [N_LED-1:0]  led_out;

  always #5 clk = ~clk;

  led_sw_ctrl #(
    .N_LED(N_LED), .N_SW(N_SW), .PWM_BITS(PWM_BITS),
    .PRESCALE(PRESCALE), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .irq(irq), .sw_in(sw_in), .led_out(led_out)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state as it should be during the current cycle.
  logic [1:0]       m_ctrl;
  logic [N_SW-1:0]  m_mask, m_edge, m_stable, m_s1, m_s2;
  logic [N_LED-1:0] m_mode, m_static, m_led;
  logic             m_irq;
  int               m_duty_sh [N_LED];
  int               m_duty_act [N_LED];
  int               m_n;
  logic [N_SW-1:0]  syn_hist [$];
  logic [31:0]      exp_q [$];

  function automatic logic [31:0] reg_value(input logic [4:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      5'd0: v = 32'(m_ctrl);
      5'd1: v = 32'(m_stable);
      5'd2: v = 32'(m_edge);
      5'd3: v = 32'(m_mask);
      5'd4: v = 32'(m_mode);
      5'd5: v = 32'(m_static);
      default: if (a >= 5'd16 && int'(a) < 16 + N_LED) v = 32'(m_duty_sh[int'(a) - 16]);
    endcase
    return v;
  endfunction

  function automatic int pwm_pos();
    return (m_n / PRESCALE) % STEPS;
  endfunction

  task automatic model_reset();
    m_ctrl = '0; m_mask = '0; m_edge = '0; m_stable = '0; m_s1 = '0; m_s2 = '0;
    m_mode = '0; m_static = '0; m_led = '0; m_irq = 1'b0; m_n = 0;
    for (int i = 0; i < N_LED; i++) begin
      m_duty_sh[i] = 0;
      m_duty_act[i] = 0;
    end
    syn_hist.delete();
    syn_hist.push_back('0);
  endtask

  // Advance the model across one rising edge using the inputs of the ending cycle.
  task automatic model_edge();
    logic [N_SW-1:0]  flips, clr;
    logic [N_LED-1:0] lvl;
    bit               all_diff;
    int               pos;
    if (reset) begin
      model_reset();
    end else begin
      pos = pwm_pos();
      for (int i = 0; i < N_LED; i++) lvl[i] = m_duty_act[i] > pos;
      // A switch is accepted once the synced value has disagreed with the
      // stable value for DEB consecutive cycles.
      flips = '0;
      if (syn_hist.size() == DEB) begin
        for (int b = 0; b < N_SW; b++) begin
          all_diff = 1'b1;
          foreach (syn_hist[j]) if (syn_hist[j][b] == m_stable[b]) all_diff = 1'b0;
          flips[b] = all_diff;
        end
      end
      clr = (avs_write && avs_address == 5'd2) ? avs_writedata[N_SW-1:0] : '0;
      m_led    = m_ctrl[0] ? ((m_mode & lvl) | (~m_mode & m_static)) : '0;
      m_irq    = m_ctrl[1] & |(m_edge & m_mask);
      m_edge   = (m_edge & ~clr) | flips;
      m_stable = m_stable ^ flips;
      m_s2     = m_s1;
      m_s1     = sw_in;
      m_n++;
      if (m_n % PERIOD == 0) begin
        for (int i = 0; i < N_LED; i++) m_duty_act[i] = m_duty_sh[i];
      end
      if (avs_write) begin
        case (avs_address)
          5'd0: m_ctrl   = avs_writedata[1:0];
          5'd3: m_mask   = avs_writedata[N_SW-1:0];
          5'd4: m_mode   = avs_writedata[N_LED-1:0];
          5'd5: m_static = avs_writedata[N_LED-1:0];
          default: if (avs_address >= 5'd16 && int'(avs_address) < 16 + N_LED)
                     m_duty_sh[int'(avs_address) - 16] = int'(avs_writedata[PWM_BITS-1:0]);
        endcase
      end
      syn_hist.push_back(m_s2);
      if (syn_hist.size() > DEB) void'(syn_hist.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic bus_read(input logic [4:0] a);
    avs_address = a; avs_read = 1'b1;
    exp_q.push_back(reg_value(a));
    tick();
    avs_read = 1'b0;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    avs_address = a; avs_write = 1'b1; avs_writedata = d;
    tick();
    avs_write = 1'b0;
  endtask

  task automatic count_high(input string name, input int exp_hi);
    int hi;
    hi = 0;
    for (int k = 0; k < PERIOD; k++) begin
      tick();
      hi += int'(led_out[0]);
    end
    check(name, hi, exp_hi);
  endtask

  task automatic wait_pos(input int target);
    for (int k = 0; k < PERIOD && pwm_pos() != target; k++) tick();
  endtask

  // Monitor: pops expected read data one cycle after each read and checks
  // the registered outputs every cycle.
  logic read_seen = 1'b0;
  bit   mon_on = 1'b0;
  always @(posedge clk) read_seen <= avs_read && !reset;

  always @(negedge clk) begin
    if (mon_on) begin
      check("led_out", 32'(led_out), 32'(m_led));
      check("irq", 32'(irq), 32'(m_irq));
      if (read_seen) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL readdata: got 0x%0h with no read outstanding", avs_readdata);
        end else begin
          check("readdata", avs_readdata, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] addr_pool [16];
    logic [4:0] a;
    int r;
    model_reset();
    for (int i = 0; i < 8; i++) addr_pool[i] = 5'(i);
    for (int i = 8; i < 16; i++) addr_pool[i] = 5'(i + 8);

    repeat (3) tick();
    mon_on = 1'b1;
    reset = 1'b0;
    tick();

    // Reset state of every register plus unmapped addresses.
    for (int i = 0; i < 16; i++) bus_read(addr_pool[i]);
    bus_read(5'd31);

    bus_write(5'd3, 32'h4);
    bus_write(5'd0, 32'h3);

    // Short glitch must be rejected.
    sw_in[2] = 1'b1;
    repeat (5) tick();
    sw_in[2] = 1'b0;
    repeat (12) tick();
    bus_read(5'd1);
    bus_read(5'd2);

    // Held input: SW_EDGE polled every cycle across the acceptance point.
    sw_in[2] = 1'b1;
    for (int k = 0; k < 13; k++) bus_read(5'd2);
    bus_read(5'd1);
    repeat (2) tick();

    // Clear drops irq; then an edge landing in the cycle of a clear persists.
    bus_write(5'd2, 32'h4);
    repeat (3) tick();
    sw_in[2] = 1'b0;
    repeat (DEB + 1) tick();
    bus_write(5'd2, 32'h4);
    bus_read(5'd2);
    repeat (2) tick();

    // Static LEDs, then global disable.
    bus_write(5'd4, 32'h0);
    bus_write(5'd5, 32'hA5);
    bus_write(5'd0, 32'h1);
    repeat (3) tick();
    bus_write(5'd0, 32'h0);
    repeat (2) tick();

    // PWM on LED 0.
    bus_write(5'd4, 32'h01);
    bus_write(5'd0, 32'h1);
    bus_write(5'd16, 32'd4);
    repeat (2 * PERIOD) tick();
    count_high("pwm_duty4", 2 * 4);

    // Mid-period update: rest of this period keeps duty 4, next one uses 12.
    wait_pos(7);
    bus_write(5'd16, 32'd12);
    begin
      int hi;
      hi = 0;
      for (int k = 0; k < PERIOD && pwm_pos() != 0; k++) begin
        tick();
        hi += int'(led_out[0]);
      end
      check("pwm_old_duty_tail", hi, 0);
    end
    count_high("pwm_new_duty12", 2 * 12);

    bus_write(5'd16, 32'd0);
    repeat (2 * PERIOD) tick();
    count_high("pwm_duty0", 0);
    bus_write(5'd16, 32'd15);
    repeat (2 * PERIOD) tick();
    count_high("pwm_duty15", 2 * 15);
    bus_read(5'd16);

    // Randomised traffic with switch activity and one mid-run reset.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        r = $urandom_range(0, N_SW - 1);
        sw_in[r] = ~sw_in[r];
      end
      a = addr_pool[$urandom_range(0, 15)];
      r = $urandom_range(0, 9);
      reset = (k == 700);
      avs_address   = a;
      avs_writedata = $urandom;
      avs_read      = (r < 4);
      avs_write     = (r >= 3 && r < 7);
      if (avs_read && !reset) exp_q.push_back(reg_value(a));
      tick();
    end
    avs_read = 1'b0;
    avs_write = 1'b0;
    reset = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
